// File: rtl/rv_pkg.sv
// Shared definitions for the RV32E fetch front end.
//   - default widths and reset PC
//   - fetch state encoding
//   - prefetch entry layout for the default 32-bit PC width
//   - canonical NOP encoding (addi x0, x0, 0)
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INSTR_W      = 32;

  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0]      NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
    logic                    fault;
  } fetch_entry_t;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with registered storage and no bypass: a word pushed at
// an edge is visible on rdata_o after that edge.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i / wdata_i   write request and data
//   pop_i              read-advance request (ignored when empty)
//   clear_i            drop all entries (wins over push/pop)
//   rdata_o            head entry (undefined content when empty)
//   full_o, empty_o    status flags
//   count_o            number of entries held
// A push while full is accepted only together with a pop.
module rv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the consumer gates the head with empty_o.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: issues in-order word fetches over a
// ready/valid memory port, buffers responses in a prefetch FIFO and hands
// (pc, instr, fault) entries to decode.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr     fetch request channel
//   imem_rsp_valid/data/err       in-order response channel (no backpressure)
//   redirect_valid/redirect_pc    branch/jump/trap redirect pulse
//   if_valid/if_ready             decode handshake
//   if_instr/if_pc/if_fault       head entry presented to decode
//   debug_pc                      next address to request
//   pipeline_flush                one-cycle pulse after a redirect
//   fetch_stall                   fetch not making progress this cycle
//   occupancy                     FIFO entries held
//
// state | meaning
// BOOT  | first cycle after reset, no requests
// RUN   | issuing requests under the credit limit
// FAULT | bus error delivered; idle until redirect
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned       XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_err,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  output logic               if_fault,
  output logic [XLEN-1:0]    debug_pc,
  output logic               pipeline_flush,
  output logic               fetch_stall,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int unsigned CRED_W = CNT_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } entry_t;

  fetch_state_t     state_q;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             flush_q;

  logic             req_fire, rsp_fire, rsp_accept, rsp_drop, fault_push;
  logic             fifo_pop, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CRED_W-1:0] credit_used;
  logic [XLEN-1:0]  redirect_target;
  entry_t           push_entry, head_entry;

  // The credit rule already keeps pushes off a full buffer; the flag and
  // the ignored low target bits are deliberately left unused.
  logic             unused_fifo_full;
  logic [1:0]       unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Buffered plus in-flight words may never exceed the buffer size, so
  // every response has a slot waiting for it.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = (state_q == RUN) && (credit_used < CRED_W'(FIFO_DEPTH))
                          && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response during a redirect belongs to the abandoned stream.
  assign rsp_fire   = imem_rsp_valid;
  assign rsp_accept = rsp_fire && !redirect_valid && (drop_cnt_q == '0);
  assign rsp_drop   = rsp_fire && !redirect_valid && (drop_cnt_q != '0);
  assign fault_push = rsp_accept && imem_rsp_err;

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data, fault: imem_rsp_err};
  assign fifo_pop   = if_valid && if_ready;

  rv_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_prefetch (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rsp_accept),
    .pop_i   (fifo_pop),
    .clear_i (redirect_valid),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign if_valid  = !fifo_empty;
  assign if_instr  = if_valid ? head_entry.instr : '0;
  assign if_pc     = if_valid ? head_entry.pc    : '0;
  assign if_fault  = if_valid && head_entry.fault;
  assign occupancy = fifo_count;
  assign debug_pc  = fetch_pc_q;
  assign pipeline_flush = flush_q;
  assign fetch_stall = ((state_q == RUN) && !imem_req_valid)
                       || (imem_req_valid && !imem_req_ready);

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    if (redirect_valid) begin
      // Everything still in flight after this edge is stale.
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
    end else begin
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end else if (fault_push) begin
        // Words fetched past the faulting one must never reach decode.
        drop_cnt_d = outstanding_d;
      end
      if (req_fire)   fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_accept) rsp_pc_d   = rsp_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      flush_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      flush_q       <= redirect_valid;
      if (redirect_valid) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          BOOT:    state_q <= RUN;
          RUN:     if (fault_push) state_q <= FAULT;
          FAULT:   state_q <= FAULT;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
module tb_rv_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int M_BOOT = 0, M_RUN = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, if_fault;
  logic [31:0] if_instr, if_pc, debug_pc;
  logic        pipeline_flush, fetch_stall;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  rv_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault), .debug_pc(debug_pc),
    .pipeline_flush(pipeline_flush), .fetch_stall(fetch_stall),
    .occupancy(occupancy)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;

  mreq_t mem_q[$];
  ent_t  exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, last_due = 0;
  int m_state, m_out, m_drop;
  logic [31:0] m_fetch, m_rsp;
  logic m_flush;

  logic drv_rst, drv_if_ready, drv_redirect;
  logic [31:0] drv_redirect_pc;
  int ready_pct, lat_min, lat_max;
  logic err_en, rand_err_en;
  logic [31:0] err_addr;

  logic s_req_valid, s_if_valid, s_if_fault, s_flush;
  logic [31:0] s_req_addr, s_if_pc;
  logic [2:0] s_occ;
  int dut_fires = 0, dut_pops = 0, first_fire = -1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (err_en && a == err_addr) || (rand_err_en && a[6:2] == 5'h1B && a[12]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_BOOT; m_out = 0; m_drop = 0;
    m_fetch = RST_PC; m_rsp = RST_PC; m_flush = 1'b0;
    exp_q.delete(); mem_q.delete(); last_due = 0;
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, advance the
  // model from what the spec says happens at the coming posedge.
  task automatic cycle();
    logic fire, rsp, pop, exp_rv, rerr;
    logic [31:0] raddr;
    int d;
    rst = drv_rst;
    if_ready = drv_if_ready;
    redirect_valid = drv_redirect;
    redirect_pc = drv_redirect_pc;
    imem_req_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
    rsp = drv_rst && mem_q.size() > 0 && mem_q[0].due <= cyc;
    raddr = rsp ? mem_q[0].addr : 32'h0;
    rerr = rsp && is_err(raddr);
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? mem_data(raddr) : $urandom;
    imem_rsp_err = rsp ? rerr : 1'($urandom_range(1));
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_if_valid = if_valid; s_if_pc = if_pc; s_if_fault = if_fault;
    s_occ = occupancy; s_flush = pipeline_flush;

    exp_rv = (m_state == M_RUN) && (exp_q.size() + m_out < DEPTH) && !drv_redirect;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
    chk("if_valid", if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("if_pc", if_pc, exp_q[0].pc);
      chk("if_instr", if_instr, exp_q[0].instr);
      chk("if_fault", if_fault, exp_q[0].fault);
    end
    if (m_state == M_BOOT) begin
      chk("boot_if_instr", if_instr, 0);
      chk("boot_if_pc", if_pc, 0);
      chk("boot_if_fault", if_fault, 0);
      chk("boot_req_addr", imem_req_addr, RST_PC);
    end
    chk("occupancy", occupancy, exp_q.size());
    chk("debug_pc", debug_pc, m_fetch);
    chk("flush", pipeline_flush, m_flush);
    chk("stall", fetch_stall, ((m_state == M_RUN) && !exp_rv) || (exp_rv && !imem_req_ready));

    if (imem_req_valid && imem_req_ready && drv_rst) begin
      dut_fires++;
      if (first_fire < 0) first_fire = cyc;
    end
    if (if_valid && drv_if_ready && drv_rst) dut_pops++;

    if (!drv_rst) begin
      model_reset();
    end else begin
      fire = exp_rv && imem_req_ready;
      pop = (exp_q.size() != 0) && drv_if_ready;
      if (rsp) void'(mem_q.pop_front());
      if (fire) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d < last_due) d = last_due;
        last_due = d;
        mem_q.push_back('{addr: m_fetch, due: d});
      end
      if (drv_redirect) begin
        m_drop = m_out + int'(fire) - int'(rsp);
        exp_q.delete();
        m_fetch = {drv_redirect_pc[31:2], 2'b00};
        m_rsp = m_fetch;
        m_state = M_RUN;
      end else begin
        if (m_state == M_BOOT) m_state = M_RUN;
        if (pop) void'(exp_q.pop_front());
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            chk("no_push_full", (occupancy < DEPTH) || pop, 1);
            exp_q.push_back('{pc: m_rsp, instr: mem_data(raddr), fault: rerr});
            m_rsp += 4;
            if (rerr) begin
              m_state = M_FAULT;
              m_drop = m_out + int'(fire) - 1;
            end
          end
        end
        if (fire) m_fetch += 4;
      end
      m_out = m_out + int'(fire) - int'(rsp);
      m_flush = drv_redirect;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    drv_redirect = 1'b1; drv_redirect_pc = pc;
    cycle();
    drv_redirect = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] pc, input logic fault);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_if_valid) found = 1'b1;
    end
    chk({tag, "_seen"}, found, 1);
    if (found) begin
      chk({tag, "_pc"}, s_if_pc, pc);
      chk({tag, "_fault"}, s_if_fault, fault);
    end
  endtask

  initial begin
    int rel, p0, f0;
    logic found;
    drv_rst = 1'b0; drv_if_ready = 1'b1; drv_redirect = 1'b0; drv_redirect_pc = '0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    err_en = 1'b0; rand_err_en = 1'b0; err_addr = '0;
    rst = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    repeat (3) cycle();

    // Reset release, 1-cycle memory, decode always ready.
    drv_rst = 1'b1;
    rel = cyc;
    repeat (8) cycle();
    chk("first_req_delay", first_fire - rel, 1);
    p0 = dut_pops;
    repeat (10) cycle();
    chk("throughput", dut_pops - p0, 10);

    // Decode stall: buffer fills and requests stop.
    drv_if_ready = 1'b0;
    repeat (10) cycle();
    chk("occ_saturated", s_occ, DEPTH);
    chk("stall_req_off", s_req_valid, 0);
    drv_if_ready = 1'b1;
    repeat (12) cycle();

    // Redirect with 3-cycle memory and requests in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && m_out != 3; i++) cycle();
    redirect_to(32'h0000_0100);
    cycle();
    chk("flush_pulse", s_flush, 1);
    cycle();
    chk("flush_single", s_flush, 0);
    wait_valid("redir100", 32'h0000_0100, 1'b0);

    // Unaligned redirect target.
    lat_min = 1; lat_max = 2;
    redirect_to(32'h0000_0203);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_req_valid) found = 1'b1;
    end
    chk("align_req_seen", found, 1);
    chk("align_req_addr", s_req_addr, 32'h0000_0200);
    wait_valid("align", 32'h0000_0200, 1'b0);

    // Bus error at 0x40, recovery via redirect to 0x80.
    err_en = 1'b1; err_addr = 32'h0000_0040; ready_pct = 80; lat_min = 1; lat_max = 3;
    redirect_to(32'h0000_0030);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_if_valid && s_if_fault) found = 1'b1;
    end
    chk("fault_seen", found, 1);
    chk("fault_pc", s_if_pc, 32'h0000_0040);
    f0 = dut_fires;
    repeat (8) cycle();
    chk("fault_no_req", dut_fires - f0, 0);
    redirect_to(32'h0000_0080);
    wait_valid("resume80", 32'h0000_0080, 1'b0);
    err_en = 1'b0;

    // Address wrap at the top of the 32-bit space.
    ready_pct = 100; lat_min = 1; lat_max = 1;
    redirect_to(32'hFFFF_FFF8);
    wait_valid("wrap_a", 32'hFFFF_FFF8, 1'b0);
    wait_valid("wrap_b", 32'hFFFF_FFFC, 1'b0);
    wait_valid("wrap_c", 32'h0000_0000, 1'b0);

    // Randomised traffic: ready, latency, decode stalls, redirects, errors.
    ready_pct = 70; lat_min = 1; lat_max = 4; rand_err_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drv_if_ready = ($urandom_range(99) < 65);
      drv_redirect = ($urandom_range(24) == 0);
      drv_redirect_pc = $urandom & 32'h0000_FFFF;
      cycle();
    end
    drv_redirect = 1'b0; drv_if_ready = 1'b1;

    // Reset mid-stream.
    drv_rst = 1'b0;
    cycle();
    drv_rst = 1'b1;
    cycle();
    chk("rst_occ", s_occ, 0);
    chk("rst_if_valid", s_if_valid, 0);
    chk("rst_req_valid", s_req_valid, 0);
    for (int i = 0; i < 100; i++) begin
      drv_if_ready = ($urandom_range(99) < 70);
      drv_redirect = ($urandom_range(29) == 0);
      drv_redirect_pc = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32E core family; replaces the combinational imem_addr/imem_data fetch with a ready/valid memory interface that tolerates variable latency.
Issues in-order requests against a credit limit, buffers returned words in a prefetch FIFO, and hands (pc, instr) pairs to decode with a valid/ready handshake.
Handles branch/jump redirects with flush and discard of in-flight responses, and bus-error faults.
Sits between instruction memory (or an I-cache) and the decode stage.

Parameters:
XLEN, 32, width of PC and address buses.
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy and outstanding counters (derived).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; responses return in request order
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  bus error for this response
redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse
redirect_pc  in  XLEN  redirect target
if_valid  out  1  decode-side entry valid
if_ready  in  1  decode accepts entry (not stalled)
if_instr  out  32  instruction
if_pc  out  XLEN  PC of if_instr
if_fault  out  1  entry carries a bus error
debug_pc  out  XLEN  current fetch PC (next address to request)
pipeline_flush  out  1  registered pulse, one cycle after redirect_valid
fetch_stall  out  1  high when imem_req_valid is low in RUN, or when a request is valid but not ready
occupancy  out  CNT_W  FIFO entries held

Behaviour:
- Reset (rst==0 at a clk edge): state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. All outputs are 0 except debug_pc=RESET_PC.
- States:
  - BOOT: one cycle, no request, then go to RUN.
  - RUN: issue requests.
  - FAULT: no requests; leave only on redirect, then go to RUN.
- Request rule: imem_req_valid = (state==RUN) && (occupancy + outstanding < FIFO_DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding increments.
- Response:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise it is pushed as {fetch-order pc, data, err}.
  - The pc is tracked by a separate rsp_pc register that advances by 4 per accepted response.
  - outstanding decrements on every response.
  - Latency from imem_rsp_valid to if_valid is 1 cycle; the FIFO is registered and has no bypass.
- Fault:
  - A pushed response with err=1 sets state=FAULT.
  - Requests already outstanding still complete. They are discarded (drop_cnt += outstanding at fault time, net of a same-cycle response).
- Decode: if_valid = FIFO not empty; if_* show the head entry; pop on if_valid && if_ready.
- Redirect (takes priority over everything):
  - Next cycle: fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO cleared.
  - drop_cnt = outstanding + (request accepted this cycle ? 1 : 0) - (response this cycle ? 1 : 0).
  - state=RUN; pipeline_flush=1 for one cycle.
  - A response arriving in the redirect cycle is discarded, never pushed.
  - A pop in the redirect cycle is honoured: decode owns that entry.
- Simultaneous push and pop when the FIFO is full: legal; occupancy is unchanged.
- Push when the FIFO is full cannot occur, because the credit rule prevents it. This is a bench assertion.
- outstanding never exceeds FIFO_DEPTH.
- Reset asserted mid-operation: immediate return to the reset state at the next edge. In-flight memory responses after reset are ignored only if drop_cnt is nonzero; the memory side is reset on the same rst.

Decomposition:
- Shared package rv_pkg:
  - XLEN_DEFAULT, INSTR_W=32, RESET_PC_DEFAULT.
  - fetch_state_t enum {BOOT, RUN, FAULT}.
  - fetch_entry_t struct {pc, instr, fault}.
  - NOP_INSTR=32'h0000_0013.
- Sub-module rv_sync_fifo (parametrised WIDTH/DEPTH; push, pop, clear, full, empty, count) holds the prefetch buffer.
- The credit counter, drop counter and state machine stay in rv_fetch_unit.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, if_ready=1 -> first request at RESET_PC on cycle 2 after release; if_pc sequence 0x0, 0x4, 0x8, ...; sustained throughput 1/cycle.
- if_ready=0 for 10 cycles, FIFO_DEPTH=4 -> occupancy saturates at 4, no more than 4 requests minus pops issued; releasing if_ready drains in order with no loss or duplication.
- Memory latency 3 cycles, redirect_valid with redirect_pc=0x100 while 3 requests are outstanding -> 3 responses dropped, next if_pc=0x100, pipeline_flush high exactly 1 cycle later.
- redirect_pc=0x203 -> fetch at 0x200 (low bits cleared).
- Response with imem_rsp_err=1 at pc 0x40 -> if_fault=1 with if_pc=0x40; no further requests until a redirect to 0x80; fetch resumes at 0x80.
- fetch_pc=0xFFFF_FFFC with XLEN=32 -> next request address 0x0000_0000.
- Assert rst low mid-stream -> all outputs return to reset values in the next cycle.
